rxe_ctrl: RTL
=============

Name: rxe_ctrl

Overview:
- Receive-buffer controller for the Ethernet RX nibble pipeline.
- Sits between the RX filter chain (nibble-valid and CRC-error flags), the packet write filter (write strobe, word address, byte length), and the RX packet memory.
- Decides when the write filter may run, gates memory writes, accepts or drops each finished packet, and holds the accepted packet for the CPU.
- Exposes one 32-bit status word and one control write strobe.

Parameters:
- AW, 12, word-address width of the RX packet memory; legal range 4..12.
- MINLEN, 64, minimum accepted packet length in bytes; shorter packets are runts.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_ce  in  1  nibble clock enable, shared with the RX datapath.
- i_rx_v  in  1  nibble valid at the write-filter input.
- i_crcerr  in  1  CRC error flag; valid when the packet ends.
- i_wr_v  in  1  write valid from the write filter.
- i_wr_addr  in  AW  word address from the write filter.
- i_wr_data  in  32  word data from the write filter.
- i_wr_len  in  AW+2  running byte length from the write filter.
- o_cancel  out  1  cancel/reset to the write filter.
- o_mem_we  out  1  packet-memory write enable.
- o_mem_addr  out  AW  packet-memory address.
- o_mem_data  out  32  packet-memory data.
- i_ctrl_wr  in  1  CPU control write strobe.
- i_ctrl_data  in  32  CPU control data.
  - bit0 = ARM/release.
  - bit1 = DISABLE.
  - bit2 = clear counters.
- o_status  out  32  status word.
- o_int  out  1  packet-ready interrupt, level.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-high on i_reset.
- Reset values:
  - State DISABLED.
  - o_cancel=1, o_mem_we=0, o_mem_addr=0, o_mem_data=0.
  - Latched length=0, both counters=0, o_int=0.
- States: DISABLED, ARMED, RECV, DRAIN, FULL.
- o_cancel is registered and equals 1 in every state except ARMED and RECV.
- Memory port is registered, 1 clock latency. When i_ce && i_wr_v && state==RECV:
  - o_mem_we=1 for one clock.
  - o_mem_addr=i_wr_addr, o_mem_data=i_wr_data.
  - Otherwise o_mem_we=0.
- RX-event transitions are evaluated only when i_ce=1. Control writes are evaluated every clock.
- ARMED:
  - i_rx_v=1 -> RECV.
- RECV:
  - Keep a registered copy of i_wr_v, updated on i_ce.
  - Packet end = i_ce && !i_wr_v && previous i_wr_v.
  - Overflow: i_wr_len > 4*2^AW -> DRAIN; missed count +1.
  - At packet end with i_crcerr=1 -> ARMED; CRC count +1.
  - Else at packet end with i_wr_len < MINLEN -> ARMED; missed count +1.
  - Else at packet end -> FULL; latch i_wr_len.
- DRAIN:
  - Stay until i_ce && !i_rx_v, then -> ARMED.
- FULL and DISABLED:
  - A rising edge of i_rx_v (sampled on i_ce) increments the missed count if the state is FULL.
  - o_int = (state==FULL).
- Control writes:
  - DISABLE has priority over ARM: any state -> DISABLED. An in-progress RECV is aborted and nothing is counted.
  - ARM from FULL or DISABLED -> ARMED if i_rx_v=0. If i_rx_v=1 -> DRAIN, so a partial packet is never captured.
  - ARM in ARMED, RECV or DRAIN is ignored.
  - Clear-counters zeroes both counters. It wins over an increment in the same clock.
- Simultaneous events:
  - A control write in the same clock as a packet end: the control write wins for DISABLE.
  - For ARM (ignored in RECV), the packet-end transition proceeds.
- Counters: 8-bit, saturate at 255.
- o_status layout:
  - [AW+1:0] latched byte length; zero-extended to bit 13.
  - [14] FULL.
  - [15] state != DISABLED.
  - [23:16] CRC-error count.
  - [31:24] missed count.

Test Plan:
1. Reset, write ARM, then a 100-byte good packet (200 nibbles, i_crcerr=0, i_ce every clock). Required:
   - o_mem_we pulses track i_wr_v one clock late.
   - FULL is reached; o_int=1.
   - o_status[13:0]=100, o_status[15:14]=2'b11.
2. While FULL, send a second packet. Required:
   - No o_mem_we; o_cancel stays 1.
   - Missed count=1; latched length stays 100.
   - Then ARM -> ARMED, o_int=0.
3. Good-length packet ending with i_crcerr=1 -> ARMED, CRC count=1, no FULL. A 40-byte packet -> missed count +1, ARMED.
4. ARM issued mid-packet (i_rx_v=1) -> DRAIN. Required:
   - No writes for the rest of that packet.
   - ARMED after i_rx_v falls.
   - The next packet is captured normally.
5. Send 260 CRC-error packets -> CRC count saturates at 255. Then a clear-counters write in the same clock as a CRC-error packet end -> count 0.
6. DISABLE written during RECV -> DISABLED next clock, o_cancel=1, counters unchanged. With AW=4, a 70-byte packet -> overflow, DRAIN, missed count +1.

Source files
------------

// File: rtl/rxe_ctrl_if.sv
// rxe_ctrl_if: write-filter to packet-memory bus of the RX buffer controller.
// i_wr_* come from the write filter; o_mem_* go to the RX packet memory.
interface rxe_ctrl_if #(
  parameter int AW = 12
);
  logic          i_wr_v;
  logic [AW-1:0] i_wr_addr;
  logic [31:0]   i_wr_data;
  logic [AW+1:0] i_wr_len;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [31:0]   o_mem_data;

  modport master (
    output i_wr_v, i_wr_addr, i_wr_data, i_wr_len,
    input  o_mem_we, o_mem_addr, o_mem_data
  );

  modport slave (
    input  i_wr_v, i_wr_addr, i_wr_data, i_wr_len,
    output o_mem_we, o_mem_addr, o_mem_data
  );
endinterface

// File: rtl/rxe_ctrl.sv
// rxe_ctrl: RX packet-buffer controller. Arms the write filter, gates memory
// writes, accepts or drops each packet and holds an accepted one for the CPU.
// Ports: i_clk/i_reset; i_ce, i_rx_v, i_crcerr from the RX chain; bus (write
// filter in, packet memory out); o_cancel; i_ctrl_wr/i_ctrl_data; o_status; o_int.
module rxe_ctrl #(
  parameter int AW     = 12,
  parameter int MINLEN = 64
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ce,
  input  logic        i_rx_v,
  input  logic        i_crcerr,
  rxe_ctrl_if.slave   bus,
  output logic        o_cancel,
  input  logic        i_ctrl_wr,
  input  logic [31:0] i_ctrl_data,
  output logic [31:0] o_status,
  output logic        o_int
);
  localparam int LW = AW + 2;
  localparam logic [LW:0] CAP = {1'b1, {LW{1'b0}}};
  localparam logic [LW:0] MIN = (LW+1)'(MINLEN);

  typedef enum logic [2:0] {
    S_DIS,
    S_ARMED,
    S_RECV,
    S_DRAIN,
    S_FULL
  } state_e;

  state_e        state_q, state_d;
  logic          cancel_q, cancel_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] run_q, run_d;
  logic          wrap_q, wrap_d;
  logic          wrv_q, wrv_d;
  logic          rxv_q, rxv_d;
  logic [7:0]    crc_q, crc_d;
  logic [7:0]    miss_q, miss_d;

  logic          wrap_now;
  logic [LW:0]   ext_len;
  logic          pkt_end;
  logic          ovf;
  logic          crc_inc;
  logic          miss_inc;
  logic          do_dis;
  logic          do_arm;
  logic          do_clr;
  logic          ctrl_unused;

  assign ctrl_unused = ^i_ctrl_data[31:3];

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    crc_inc  = 1'b0;
    miss_inc = 1'b0;
    do_dis   = i_ctrl_wr & i_ctrl_data[1];
    do_arm   = i_ctrl_wr & i_ctrl_data[0];
    do_clr   = i_ctrl_wr & i_ctrl_data[2];
    wrv_d    = i_ce ? bus.i_wr_v : wrv_q;
    rxv_d    = i_ce ? i_rx_v : rxv_q;
    // The filter length is only LW bits; a drop in the running
    // length means it wrapped, which restores the lost carry bit.
    wrap_now = wrap_q | (bus.i_wr_v & (bus.i_wr_len < run_q));
    ext_len  = {wrap_now, bus.i_wr_len};
    pkt_end  = i_ce & ~bus.i_wr_v & wrv_q;
    ovf      = i_ce & bus.i_wr_v & (ext_len > CAP);

    unique case (state_q)
      S_ARMED: begin
        if (i_ce && i_rx_v) state_d = S_RECV;
      end
      S_RECV: begin
        if (ovf) begin
          state_d  = S_DRAIN;
          miss_inc = 1'b1;
        end else if (pkt_end) begin
          if (i_crcerr) begin
            state_d = S_ARMED;
            crc_inc = 1'b1;
          end else if (ext_len < MIN) begin
            state_d  = S_ARMED;
            miss_inc = 1'b1;
          end else begin
            state_d = S_FULL;
            len_d   = bus.i_wr_len;
          end
        end
      end
      S_DRAIN: begin
        if (i_ce && !i_rx_v) state_d = S_ARMED;
      end
      S_FULL: begin
        miss_inc = i_ce & i_rx_v & ~rxv_q;
      end
      default: ;
    endcase

    // A disable aborts a packet in flight without any bookkeeping.
    if (do_dis) begin
      state_d = S_DIS;
      if (state_q == S_RECV) begin
        crc_inc  = 1'b0;
        miss_inc = 1'b0;
        len_d    = len_q;
      end
    end else if (do_arm &&
                 (state_q == S_FULL || state_q == S_DIS)) begin
      state_d = i_rx_v ? S_DRAIN : S_ARMED;
    end

    if (state_q != S_RECV) begin
      run_d  = '0;
      wrap_d = 1'b0;
    end else if (i_ce && bus.i_wr_v) begin
      run_d  = bus.i_wr_len;
      wrap_d = wrap_now;
    end else begin
      run_d  = run_q;
      wrap_d = wrap_q;
    end

    crc_d = crc_q;
    if (do_clr) crc_d = '0;
    else if (crc_inc && crc_q != 8'hff) crc_d = crc_q + 8'd1;

    miss_d = miss_q;
    if (do_clr) miss_d = '0;
    else if (miss_inc && miss_q != 8'hff) miss_d = miss_q + 8'd1;

    cancel_d = ~(state_d == S_ARMED || state_d == S_RECV);
    we_d     = i_ce & bus.i_wr_v & (state_q == S_RECV);
    addr_d   = we_d ? bus.i_wr_addr : addr_q;
    data_d   = we_d ? bus.i_wr_data : data_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= S_DIS;
      cancel_q <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      len_q    <= '0;
      run_q    <= '0;
      wrap_q   <= 1'b0;
      wrv_q    <= 1'b0;
      rxv_q    <= 1'b0;
      crc_q    <= '0;
      miss_q   <= '0;
    end else begin
      state_q  <= state_d;
      cancel_q <= cancel_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      len_q    <= len_d;
      run_q    <= run_d;
      wrap_q   <= wrap_d;
      wrv_q    <= wrv_d;
      rxv_q    <= rxv_d;
      crc_q    <= crc_d;
      miss_q   <= miss_d;
    end
  end

  assign o_cancel       = cancel_q;
  assign bus.o_mem_we   = we_q;
  assign bus.o_mem_addr = addr_q;
  assign bus.o_mem_data = data_q;
  assign o_int          = (state_q == S_FULL);
  assign o_status = {miss_q, crc_q,
                     state_q != S_DIS, state_q == S_FULL,
                     14'(len_q)};
endmodule
